// File: rtl/servo_update_scheduler.sv
// Servo update scheduler: holds per-channel targets, slews current positions
// once per frame and presents changed channels one at a time on duty/load.
module servo_update_scheduler #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned DUTY_W      = 8,
    parameter int unsigned FRAME_TICKS = 1000000,
    parameter int unsigned STEP_MAX    = 4,
    parameter int unsigned RESET_DUTY  = 128
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        enable,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(CHANNELS):0]   wr_chan,
    input  logic [DUTY_W-1:0]           wr_target,
    output logic                        wr_err,
    output logic [CHANNELS-1:0]         load,
    output logic [DUTY_W-1:0]           duty,
    output logic                        busy
);

    localparam int unsigned IDX_W = $clog2(CHANNELS);
    localparam int unsigned WC_W  = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(FRAME_TICKS);

    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(CHANNELS - 1);
    localparam logic [WC_W-1:0]       CH_LIM   = WC_W'(CHANNELS);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic signed [DUTY_W:0] STEP_S  = (DUTY_W+1)'(STEP_MAX);
    localparam logic [DUTY_W-1:0]     STEP_U   = DUTY_W'(STEP_MAX);
    localparam logic [DUTY_W-1:0]     RST_VAL  = DUTY_W'(RESET_DUTY);

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t               state, state_next;
    logic [IDX_W-1:0]     idx, idx_next;
    logic [CNT_W-1:0]     cnt;
    logic                 tick;
    logic                 force_q;
    logic [DUTY_W-1:0]    target [CHANNELS];
    logic [DUTY_W-1:0]    cur    [CHANNELS];

    logic [DUTY_W-1:0]    cur_sel, tgt_sel, slew_next;
    logic signed [DUTY_W:0] diff;
    logic                 wr_acc, wr_in_range;
    logic [CHANNELS-1:0]  load_next;
    logic [DUTY_W-1:0]    duty_next;
    logic                 busy_next, wr_ready_next;

    assign tick        = enable && (cnt == CNT_LAST);
    assign wr_acc      = wr_valid && wr_ready;
    assign wr_in_range = (wr_chan < CH_LIM);

    // Frame counter: free-runs while enabled, held at zero otherwise.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)              cnt <= '0;
        else if (!enable)         cnt <= '0;
        else if (cnt == CNT_LAST) cnt <= '0;
        else                      cnt <= cnt + CNT_W'(1);
    end

    // FSM state and sweep index register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Next-state: a tick starts a sweep that always runs to the last channel.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_next = SWEEP;
                    idx_next   = '0;
                end
            end
            SWEEP: begin
                if (idx == IDX_LAST) state_next = IDLE;
                else                 idx_next   = idx + IDX_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Slew toward target by at most STEP_MAX; clamping to target avoids overshoot and wrap.
    always_comb begin
        cur_sel = cur[idx];
        tgt_sel = target[idx];
        diff    = signed'({1'b0, tgt_sel}) - signed'({1'b0, cur_sel});
        if (diff > STEP_S)       slew_next = cur_sel + STEP_U;
        else if (diff < -STEP_S) slew_next = cur_sel - STEP_U;
        else                     slew_next = tgt_sel;
    end

    // Output decode: strobe a channel only if it moved or a full resend is forced.
    always_comb begin
        load_next     = '0;
        duty_next     = duty;
        busy_next     = (state_next == SWEEP);
        wr_ready_next = (state_next == IDLE);
        if (state == SWEEP && (slew_next != cur_sel || force_q)) begin
            load_next[idx] = 1'b1;
            duty_next      = slew_next;
        end
    end

    // Registered outputs, target/position storage and force flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            load     <= '0;
            duty     <= '0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            wr_err   <= 1'b0;
            force_q  <= 1'b1;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                target[i] <= RST_VAL;
                cur[i]    <= RST_VAL;
            end
        end else begin
            load     <= load_next;
            duty     <= duty_next;
            busy     <= busy_next;
            wr_ready <= wr_ready_next;
            wr_err   <= wr_acc && !wr_in_range;
            if (wr_acc && wr_in_range) target[wr_chan[IDX_W-1:0]] <= wr_target;
            if (state == SWEEP) begin
                cur[idx] <= slew_next;
                if (idx == IDX_LAST) force_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_servo_update_scheduler.sv
// Scoreboard bench for servo_update_scheduler (CHANNELS=4, FRAME_TICKS=20).
module tb_servo_update_scheduler;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b1;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_chan = '0;
    logic [7:0] wr_target = '0;
    logic       wr_err;
    logic [3:0] load;
    logic [7:0] duty;
    logic       busy;

    servo_update_scheduler #(
        .CHANNELS(4), .DUTY_W(8), .FRAME_TICKS(20), .STEP_MAX(4), .RESET_DUTY(128)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan),
        .wr_target(wr_target), .wr_err(wr_err), .load(load), .duty(duty), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [3:0] ld;
        logic [7:0] dt;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   err_cyc = -1;
    int   n_chk = 0;
    int   n_pass = 0;

    // Cycle number since reset release; equals the DUT frame count in frame 0.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic push(input int c, input int ch, input int d);
        exp_t e;
        e.cyc = c;
        e.ld  = 4'(1 << ch);
        e.dt  = 8'(d);
        q.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic wr(input int n, input int ch, input int val);
        at(n);
        wr_valid  = 1'b1;
        wr_chan   = 3'(ch);
        wr_target = 8'(val);
        @(negedge clock);
        wr_valid  = 1'b0;
    endtask

    // Monitor: per-cycle status checks, and scoreboard pop on every strobe.
    logic busy_e;
    exp_t e_m;
    initial begin
        forever begin
            @(negedge clock);
            busy_e = (cyc >= 20) && ((cyc % 20) < 4);
            chk("busy", 32'(busy), 32'(busy_e));
            chk("wr_ready", 32'(wr_ready), 32'(!busy_e));
            chk("wr_err", 32'(wr_err), 32'(cyc == err_cyc));
            if (load != 4'b0) begin
                if (q.size() == 0) begin
                    chk("unexpected_load", 32'(load), 32'd0);
                end else begin
                    e_m = q.pop_front();
                    chk("load_cycle", 32'(cyc), 32'(e_m.cyc));
                    chk("load", 32'(load), 32'(e_m.ld));
                    chk("duty", 32'(duty), 32'(e_m.dt));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clock);
        chk("reset_outputs", {20'd0, load, duty}, 32'd0);
        chk("reset_busy_err", {30'd0, busy, wr_err}, 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // Forced first frame resends all channels at reset value; frame 1 is silent.
        for (int i = 0; i < 4; i++) push(21 + i, i, 128);

        // ch1 slews 128 -> 140 over three frames.
        wr(45, 1, 140);
        push(62, 1, 132);
        push(82, 1, 136);
        push(102, 1, 140);

        // ch2 moves 3 down with no overshoot; ch3 climbs to 253, then 255 without wrap.
        wr(125, 2, 125);
        wr(126, 3, 253);
        push(143, 2, 125);
        for (int j = 0; j <= 30; j++) push(20 * (6 + j) + 24, 3, 128 + 4 * (j + 1));
        push(764, 3, 253);
        wr(765, 3, 255);
        push(784, 3, 255);

        // Out-of-range channel: error pulse, no strobes in frame 40.
        err_cyc = 806;
        wr(805, 5, 7);

        // Write held through a sweep; accepted in first idle cycle (844).
        at(840);
        wr_valid  = 1'b1;
        wr_chan   = 3'd0;
        wr_target = 8'd100;
        at(845);
        wr_valid  = 1'b0;
        push(861, 0, 124);

        // ch2 130 from 125: one step of +4; reset lands on its strobe.
        wr(865, 2, 130);
        push(881, 0, 120);
        push(883, 2, 129);
        at(883);
        #2;
        resetn = 1'b0;
        #1;
        chk("load_async_reset", 32'(load), 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) push(21 + i, i, 128);
        at(50);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
